minmax_tracker_16b: RTL

MINMAX_TRACKER_16B -- requirements
Module: minmax_tracker_16b

---
 rtl/minmax_tracker_16b.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/minmax_tracker_16b.sv
// Windowed min/max tracker: after start, accepts WINDOW unsigned 16-bit samples and
// reports the extremes plus the index of their first occurrence, one cycle after the last accept.
module minmax_tracker_16b #(
  parameter int WINDOW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] max_out,
  output logic [15:0] min_out,
  output logic [7:0]  max_idx,
  output logic [7:0]  min_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] WINDOW_C = 8'(WINDOW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  count_r;
  logic [15:0] wmax_r;
  logic [15:0] wmin_r;
  logic [7:0]  wmax_idx_r;
  logic [7:0]  wmin_idx_r;

  logic        accept_s;
  logic        last_s;
  logic [15:0] nmax_s;
  logic [15:0] nmin_s;
  logic [7:0]  nmax_idx_s;
  logic [7:0]  nmin_idx_s;

  // in_ready is a registered copy of (state == ACCUM), so it qualifies the accept directly.
  assign accept_s = in_valid & in_ready;
  assign last_s   = (count_r == (WINDOW_C - 8'd1));

  // Working extremes including the sample on the bus, so the final accept can publish directly.
  always_comb begin
    nmax_s     = wmax_r;
    nmin_s     = wmin_r;
    nmax_idx_s = wmax_idx_r;
    nmin_idx_s = wmin_idx_r;
    if (count_r == 8'd0) begin
      nmax_s     = in_data;
      nmin_s     = in_data;
      nmax_idx_s = 8'd0;
      nmin_idx_s = 8'd0;
    end else begin
      if (in_data > wmax_r) begin
        nmax_s     = in_data;
        nmax_idx_s = count_r;
      end else begin
        nmax_s     = wmax_r;
        nmax_idx_s = wmax_idx_r;
      end
      if (in_data < wmin_r) begin
        nmin_s     = in_data;
        nmin_idx_s = count_r;
      end else begin
        nmin_s     = wmin_r;
        nmin_idx_s = wmin_idx_r;
      end
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      count_r    <= 8'd0;
      wmax_r     <= 16'd0;
      wmin_r     <= 16'd0;
      wmax_idx_r <= 8'd0;
      wmin_idx_r <= 8'd0;
      max_out    <= 16'd0;
      min_out    <= 16'd0;
      max_idx    <= 8'd0;
      min_idx    <= 8'd0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r  <= ST_ACCUM;
            count_r  <= 8'd0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            wmax_r     <= nmax_s;
            wmin_r     <= nmin_s;
            wmax_idx_r <= nmax_idx_s;
            wmin_idx_r <= nmin_idx_s;
            count_r    <= count_r + 8'd1;
            if (last_s) begin
              state_r  <= ST_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              max_out  <= nmax_s;
              min_out  <= nmin_s;
              max_idx  <= nmax_idx_s;
              min_idx  <= nmin_idx_s;
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= ST_ACCUM;
          end
        end
        ST_DONE: begin
          state_r  <= ST_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
